// File: rtl/traffic_run_ctrl.sv
// Per-node run sequencer for a NoC traffic generator: delayed start, budgeted run,
// bounded drain, then a single report pulse and a held done level.
module traffic_run_ctrl #(
  parameter int MAX_PCK_NUM  = 10000,
  parameter int MAX_SIM_CLKs = 100000,
  parameter int DLYw         = 10,
  parameter int DRAIN_CLKs   = 1000,
  localparam int PCK_CNTw    = $clog2(MAX_PCK_NUM + 1),
  localparam int CLK_CNTw    = $clog2(MAX_SIM_CLKs + 1),
  localparam int DRNw        = $clog2(DRAIN_CLKs + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                abort,
  input  logic [DLYw-1:0]     start_delay,
  input  logic [PCK_CNTw-1:0] pck_budget,
  input  logic [CLK_CNTw-1:0] clk_budget,
  input  logic                sent_done,
  input  logic                noc_idle,
  output logic                start,
  output logic                stop,
  output logic                report,
  output logic                done,
  output logic [PCK_CNTw-1:0] sent_cnt,
  output logic [CLK_CNTw-1:0] run_clks,
  output logic [1:0]          stop_reason
);

  typedef enum logic [2:0] {IDLE, DELAY, RUN, DRAIN, REPORT, DONE} state_t;

  localparam logic [PCK_CNTw-1:0] PCK_MAX  = PCK_CNTw'(MAX_PCK_NUM);
  localparam logic [CLK_CNTw-1:0] CLK_MAX  = CLK_CNTw'(MAX_SIM_CLKs);
  localparam logic [DRNw-1:0]     DRN_LAST = DRNw'(DRAIN_CLKs - 1);
  localparam logic [1:0] RSN_NONE = 2'd0, RSN_PCK = 2'd1, RSN_CLK = 2'd2, RSN_ABORT = 2'd3;

  state_t                state_q, state_d;
  logic [DLYw-1:0]       dly_q, dly_d;
  logic [DRNw-1:0]       drn_q, drn_d;
  logic [PCK_CNTw-1:0]   pck_bud_q, pck_bud_d;
  logic [CLK_CNTw-1:0]   clk_bud_q, clk_bud_d;
  logic [PCK_CNTw-1:0]   sent_q, sent_d;
  logic [CLK_CNTw-1:0]   run_q, run_d;
  logic [1:0]            reason_q, reason_d;
  logic                  start_q, start_d, stop_q, stop_d;
  logic                  report_q, report_d, done_q, done_d;

  logic [PCK_CNTw-1:0]   sent_nxt;
  logic [CLK_CNTw-1:0]   run_nxt;
  logic                  pck_hit, clk_hit;

  // Stop decisions look at the counts as they will be after this edge.
  assign sent_nxt = (sent_done && sent_q != PCK_MAX) ? sent_q + 1'b1 : sent_q;
  assign run_nxt  = (run_q != CLK_MAX) ? run_q + 1'b1 : run_q;
  assign pck_hit  = (pck_bud_q != '0) && (sent_nxt == pck_bud_q);
  assign clk_hit  = ((clk_bud_q != '0) && (run_nxt == clk_bud_q)) || (run_nxt == CLK_MAX);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    drn_d     = drn_q;
    pck_bud_d = pck_bud_q;
    clk_bud_d = clk_bud_q;
    sent_d    = sent_q;
    run_d     = run_q;
    reason_d  = reason_q;
    start_d   = 1'b0;
    report_d  = 1'b0;
    stop_d    = stop_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        done_d = 1'b0;
        if (go) begin
          pck_bud_d = (pck_budget > PCK_MAX) ? PCK_MAX : pck_budget;
          clk_bud_d = (clk_budget > CLK_MAX) ? CLK_MAX : clk_budget;
          sent_d    = '0;
          run_d     = '0;
          reason_d  = RSN_NONE;
          if (start_delay == '0) begin
            state_d = RUN;
            start_d = 1'b1;
          end else begin
            state_d = DELAY;
            dly_d   = start_delay - 1'b1;
          end
        end
      end
      DELAY: begin
        if (abort) begin
          state_d  = IDLE;
          reason_d = RSN_ABORT;
        end else if (dly_q == '0) begin
          state_d = RUN;
          start_d = 1'b1;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      RUN: begin
        sent_d = sent_nxt;
        run_d  = run_nxt;
        if (abort || pck_hit || clk_hit) begin
          state_d  = DRAIN;
          stop_d   = 1'b1;
          drn_d    = '0;
          reason_d = abort ? RSN_ABORT : (pck_hit ? RSN_PCK : RSN_CLK);
        end
      end
      DRAIN: begin
        sent_d = sent_nxt;
        if (noc_idle || drn_q == DRN_LAST) begin
          state_d  = REPORT;
          report_d = 1'b1;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      REPORT: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        if (!go) begin
          state_d = IDLE;
          done_d  = 1'b0;
          stop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      drn_q     <= '0;
      pck_bud_q <= '0;
      clk_bud_q <= '0;
      sent_q    <= '0;
      run_q     <= '0;
      reason_q  <= RSN_NONE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      report_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      drn_q     <= drn_d;
      pck_bud_q <= pck_bud_d;
      clk_bud_q <= clk_bud_d;
      sent_q    <= sent_d;
      run_q     <= run_d;
      reason_q  <= reason_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      report_q  <= report_d;
      done_q    <= done_d;
    end
  end

  assign start       = start_q;
  assign stop        = stop_q;
  assign report      = report_q;
  assign done        = done_q;
  assign sent_cnt    = sent_q;
  assign run_clks    = run_q;
  assign stop_reason = reason_q;

endmodule

// File: tb/tb_traffic_run_ctrl.sv
// Bench for traffic_run_ctrl: each run pushes its expected final counts, and the
// report monitor pops and compares them when the report pulse appears.
module tb_traffic_run_ctrl;
  localparam int PW = 14, CW = 17, DW = 10, DRAIN = 1000;

  logic clk = 1'b0, reset = 1'b1, go = 1'b0, abort = 1'b0, sent_done = 1'b0, noc_idle = 1'b0;
  logic [DW-1:0] start_delay = '0;
  logic [PW-1:0] pck_budget = '0;
  logic [CW-1:0] clk_budget = '0;
  logic start, stop, report, done;
  logic [PW-1:0] sent_cnt;
  logic [CW-1:0] run_clks;
  logic [1:0] stop_reason;

  int errors = 0, checks = 0, txn = 0;

  typedef struct {string name; int sent; int run; int reason;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  traffic_run_ctrl #(.MAX_PCK_NUM(10000), .MAX_SIM_CLKs(100000), .DLYw(DW), .DRAIN_CLKs(DRAIN)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .start_delay(start_delay),
    .pck_budget(pck_budget), .clk_budget(clk_budget), .sent_done(sent_done), .noc_idle(noc_idle),
    .start(start), .stop(stop), .report(report), .done(done),
    .sent_cnt(sent_cnt), .run_clks(run_clks), .stop_reason(stop_reason)
  );

  // Scoreboard consumer: every report pulse must match the oldest pending run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (report === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_report: report=1 with no run pending, required 0");
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d %s: sent=%0d run=%0d reason=%0d (exp %0d/%0d/%0d)", txn, e.name,
                   sent_cnt, run_clks, stop_reason, e.sent, e.run, e.reason);
          checks++;
          if (sent_cnt !== PW'(e.sent)) begin
            errors++; $display("FAIL %s_sent: got %0d required %0d", e.name, sent_cnt, e.sent);
          end
          checks++;
          if (run_clks !== CW'(e.run)) begin
            errors++; $display("FAIL %s_run: got %0d required %0d", e.name, run_clks, e.run);
          end
          checks++;
          if (stop_reason !== 2'(e.reason)) begin
            errors++; $display("FAIL %s_reason: got %0d required %0d", e.name, stop_reason, e.reason);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input string name, input int s, input int r, input int rsn);
    exp_t e;
    e.name = name; e.sent = s; e.run = r; e.reason = rsn;
    sb.push_back(e);
  endtask

  task automatic launch(input int dly, input int pck, input int cb);
    start_delay = DW'(dly); pck_budget = PW'(pck); clk_budget = CW'(cb);
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic drive_run(input logic [31:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      sent_done = pat[k];
      step();
    end
    sent_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({start, stop, report, done, sent_cnt, run_clks, stop_reason} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b required all 0",
                         {start, stop, report, done, sent_cnt, run_clks, stop_reason});
    end
    reset = 1'b0;
    repeat (2) step();
    checks++;
    if ({start, stop, report, done, sent_cnt, run_clks, stop_reason} !== '0) begin
      errors++; $display("FAIL idle_outputs: got %b required all 0",
                         {start, stop, report, done, sent_cnt, run_clks, stop_reason});
    end
  endtask

  task automatic test_start_delay();
    logic [9:0] smask, pmask;
    bit ok;
    noc_idle = 1'b1;
    push("delay3", 0, 5, 2);
    launch(3, 0, 5);
    for (int i = 0; i < 10; i++) begin
      smask[i] = start; pmask[i] = stop;
      step();
    end
    checks++;
    if (smask !== 10'b00_0000_1000) begin
      errors++; $display("FAIL delay3_start: start pattern %b required %b", smask, 10'b00_0000_1000);
    end
    checks++;
    if (pmask !== 10'b11_0000_0000) begin
      errors++; $display("FAIL delay3_stop: stop pattern %b required %b", pmask, 10'b11_0000_0000);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL delay3_done: done=0 required 1"); end
    step();
    checks++;
    if ({done, stop} !== 2'b00) begin
      errors++; $display("FAIL delay3_idle: done,stop=%b required 00", {done, stop});
    end
  endtask

  task automatic test_pck_budget();
    bit ok;
    noc_idle = 1'b1;
    push("pck4", 4, 7, 1);
    launch(0, 4, 0);
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL pck4_start: start=%b required 1", start); end
    drive_run(32'h1A, 6);
    checks++;
    if ({stop, sent_cnt} !== {1'b0, PW'(3)}) begin
      errors++; $display("FAIL pck4_prestop: stop=%b sent=%0d required 0/3", stop, sent_cnt);
    end
    drive_run(32'h1, 1);
    checks++;
    if ({stop, stop_reason} !== 3'b1_01) begin
      errors++; $display("FAIL pck4_stop: stop=%b reason=%0d required 1/1", stop, stop_reason);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pck4_done: done=0 required 1"); end
    step();
  endtask

  task automatic test_clk_budget();
    bit ok;
    int cnt;
    noc_idle = 1'b0;
    push("clk50", 1, 50, 2);
    launch(0, 0, 50);
    drive_run(32'h0, 49);
    checks++;
    if ({stop, run_clks} !== {1'b0, CW'(49)}) begin
      errors++; $display("FAIL clk50_prestop: stop=%b run=%0d required 0/49", stop, run_clks);
    end
    drive_run(32'h0, 1);
    checks++;
    if ({stop, run_clks, stop_reason} !== {1'b1, CW'(50), 2'd2}) begin
      errors++; $display("FAIL clk50_stop: stop=%b run=%0d reason=%0d required 1/50/2",
                         stop, run_clks, stop_reason);
    end
    cnt = 0;
    while (report !== 1'b1 && cnt < 2 * DRAIN) begin
      cnt++;
      sent_done = (cnt == 1);
      step();
    end
    sent_done = 1'b0;
    checks++;
    if (cnt != DRAIN) begin
      errors++; $display("FAIL clk50_drain_len: drain cycles %0d required %0d", cnt, DRAIN);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clk50_done: done=0 required 1"); end
    step();
  endtask

  task automatic test_both_budgets();
    bit ok;
    int rises;
    logic prev;
    noc_idle = 1'b1;
    push("both", 2, 20, 1);
    launch(0, 2, 20);
    rises = 0; prev = stop;
    for (int k = 0; k < 20; k++) begin
      sent_done = (k == 4) || (k == 19);
      step();
      if (stop === 1'b1 && prev !== 1'b1) rises++;
      prev = stop;
    end
    sent_done = 1'b0;
    checks++;
    if ({stop, stop_reason} !== 3'b1_01) begin
      errors++; $display("FAIL both_stop: stop=%b reason=%0d required 1/1", stop, stop_reason);
    end
    wait_done(20, ok);
    checks++;
    if (!ok || rises != 1) begin
      errors++; $display("FAIL both_single_stop: done=%b stop rises=%0d required 1/1", ok, rises);
    end
    step();
  endtask

  task automatic test_abort();
    bit ok, seen;
    launch(5, 0, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({stop, stop_reason} !== 3'b0_11) begin
      errors++; $display("FAIL abort_dly: stop=%b reason=%0d required 0/3", stop, stop_reason);
    end
    seen = 1'b0;
    repeat (10) begin
      if (start !== 1'b0 || done !== 1'b0 || report !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_dly_quiet: activity seen=1 required 0"); end
    noc_idle = 1'b1;
    push("abort_run", 3, 4, 3);
    launch(0, 3, 0);
    drive_run(32'h5, 3);
    abort = 1'b1; sent_done = 1'b1;
    step();
    abort = 1'b0; sent_done = 1'b0;
    checks++;
    if ({stop, stop_reason, sent_cnt} !== {1'b1, 2'd3, PW'(3)}) begin
      errors++; $display("FAIL abort_run_stop: stop=%b reason=%0d sent=%0d required 1/3/3",
                         stop, stop_reason, sent_cnt);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_run_done: done=0 required 1"); end
    step();
  endtask

  task automatic test_reset_drain();
    bit ok;
    noc_idle = 1'b0;
    launch(0, 0, 5);
    drive_run(32'h0, 5);
    checks++;
    if (stop !== 1'b1) begin errors++; $display("FAIL rst_drain_entry: stop=%b required 1", stop); end
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({start, stop, report, done, sent_cnt, run_clks, stop_reason} !== '0) begin
      errors++; $display("FAIL rst_async: got %b required all 0",
                         {start, stop, report, done, sent_cnt, run_clks, stop_reason});
    end
    repeat (2) step();
    reset = 1'b0;
    step();
    noc_idle = 1'b1;
    push("restart", 1, 1, 1);
    launch(2, 1, 0);
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL restart_early: start=%b required 0", start); end
    repeat (2) step();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL restart_start: start=%b required 1", start); end
    drive_run(32'h1, 1);
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_done: done=0 required 1"); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok, held;
    noc_idle = 1'b1;
    push("b2b_a", 1, 1, 1);
    launch(0, 1, 0);
    drive_run(32'h1, 1);
    wait_done(20, ok);
    go = 1'b1;
    held = ok;
    repeat (3) begin
      step();
      if (done !== 1'b1 || start !== 1'b0) held = 1'b0;
    end
    go = 1'b0;
    checks++;
    if (!held) begin errors++; $display("FAIL b2b_hold: done held=%b required 1", held); end
    step();
    checks++;
    if ({done, stop} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: done,stop=%b required 00", {done, stop});
    end
    push("b2b_b", 1, 2, 1);
    launch(0, 1, 0);
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL b2b_start: start=%b required 1", start); end
    drive_run(32'h2, 2);
    wait_done(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done: done=0 required 1"); end
    step();
  endtask

  initial begin
    test_reset();
    test_start_delay();
    test_pck_budget();
    test_clk_budget();
    test_both_budgets();
    test_abort();
    test_reset_drain();
    test_back_to_back();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: %0d runs never reported, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
